// File: rtl/axis_lfsr_checker.sv
// -----------------------------------------------------------------------------
// axis_lfsr_checker
//   AXI4-Stream slave that checks a received 64-bit PRBS stream produced by
//   the LFSR generator (next = {cur[62:0], cur[62] ~^ cur[61]}).
//   SEARCH state: every accepted beat reseeds the reference from the data.
//   LOCK_COUNT consecutive predicted beats enter LOCKED.
//   LOCKED state: the reference free-runs. Compared words, errored words and
//   errored bits are counted. UNLOCK_COUNT consecutive bad beats return the
//   checker to SEARCH.
//
// Ports
//   aclk, aresetn     clock, synchronous active-low reset
//   clear             synchronous pulse, zeroes the three counters
//   s_axis_tready     slave ready; high from the first edge after reset
//   s_axis_tdata      received PRBS word
//   s_axis_tvalid     slave valid
//   locked            high while in LOCKED
//   word_count        beats compared while LOCKED (saturating)
//   error_count       mismatching beats while LOCKED (saturating)
//   bit_error_count   total differing bits while LOCKED (saturating)
// -----------------------------------------------------------------------------
module axis_lfsr_checker #(
  parameter int AXIS_TDATA_WIDTH = 64,
  parameter int CNTR_WIDTH       = 32,
  parameter int LOCK_COUNT       = 4,
  parameter int UNLOCK_COUNT     = 4
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        clear,
  output logic                        s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        locked,
  output logic [CNTR_WIDTH-1:0]       word_count,
  output logic [CNTR_WIDTH-1:0]       error_count,
  output logic [CNTR_WIDTH-1:0]       bit_error_count
);

  localparam logic [0:0] ST_SEARCH = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  localparam int PC_WIDTH  = $clog2(AXIS_TDATA_WIDTH + 1);
  // The sum is wide enough for both operands plus a carry, so a popcount
  // wider than a narrow counter still saturates correctly.
  localparam int SUM_WIDTH = ((CNTR_WIDTH > PC_WIDTH) ? CNTR_WIDTH : PC_WIDTH) + 1;

  localparam logic [AXIS_TDATA_WIDTH-1:0] REF_RESET = {(AXIS_TDATA_WIDTH/2){2'b01}};

  function automatic logic [AXIS_TDATA_WIDTH-1:0] nxt(input logic [AXIS_TDATA_WIDTH-1:0] x);
    return {x[AXIS_TDATA_WIDTH-2:0], x[62] ~^ x[61]};
  endfunction

  logic [0:0]                  state;
  logic                        tready_q;
  logic                        seed_valid;
  logic [AXIS_TDATA_WIDTH-1:0] ref_q;
  logic [31:0]                 match_cnt;
  logic [31:0]                 miss_cnt;

  logic                        beat;
  logic [AXIS_TDATA_WIDTH-1:0] err;
  logic                        err_any;
  logic [PC_WIDTH-1:0]         err_pop;
  logic [31:0]                 match_inc;
  logic [31:0]                 miss_inc;
  logic [SUM_WIDTH-1:0]        bit_sum;
  logic [CNTR_WIDTH-1:0]       bit_sat;

  assign beat      = s_axis_tvalid & tready_q;
  assign err       = s_axis_tdata ^ ref_q;
  assign err_any   = |err;
  assign match_inc = match_cnt + 32'd1;
  assign miss_inc  = miss_cnt + 32'd1;

  always_comb begin
    err_pop = '0;
    for (int unsigned i = 0; i < AXIS_TDATA_WIDTH; i++) begin
      err_pop = err_pop + PC_WIDTH'(err[i]);
    end
  end

  always_comb begin
    bit_sum = SUM_WIDTH'(bit_error_count) + SUM_WIDTH'(err_pop);
    bit_sat = (|bit_sum[SUM_WIDTH-1:CNTR_WIDTH]) ? '1 : bit_sum[CNTR_WIDTH-1:0];
  end

  // Synchronisation state machine and reference register.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state      <= ST_SEARCH;
      tready_q   <= 1'b0;
      seed_valid <= 1'b0;
      ref_q      <= REF_RESET;
      match_cnt  <= '0;
      miss_cnt   <= '0;
    end else begin
      tready_q <= 1'b1;
      if (beat) begin
        if (state == ST_SEARCH) begin
          ref_q      <= nxt(s_axis_tdata);
          seed_valid <= 1'b1;
          if (seed_valid && !err_any) begin
            match_cnt <= match_inc;
            if (match_inc == LOCK_COUNT) begin
              state    <= ST_LOCKED;
              miss_cnt <= '0;
            end
          end else begin
            match_cnt <= '0;
          end
        end else begin
          ref_q <= nxt(ref_q);
          if (err_any) begin
            miss_cnt <= miss_inc;
            // On loss of lock the reseed overrides the free-running update.
            if (miss_inc == UNLOCK_COUNT) begin
              state      <= ST_SEARCH;
              match_cnt  <= '0;
              ref_q      <= nxt(s_axis_tdata);
              seed_valid <= 1'b1;
            end
          end else begin
            miss_cnt <= '0;
          end
        end
      end
    end
  end

  // Saturating statistics counters; clear takes priority over a beat.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      word_count      <= '0;
      error_count     <= '0;
      bit_error_count <= '0;
    end else if (clear) begin
      word_count      <= '0;
      error_count     <= '0;
      bit_error_count <= '0;
    end else if (beat && (state == ST_LOCKED)) begin
      if (!(&word_count)) begin
        word_count <= word_count + CNTR_WIDTH'(1);
      end
      if (err_any) begin
        if (!(&error_count)) begin
          error_count <= error_count + CNTR_WIDTH'(1);
        end
        bit_error_count <= bit_sat;
      end
    end
  end

  assign s_axis_tready = tready_q;
  assign locked        = (state == ST_LOCKED);

endmodule

// File: tb/tb_axis_lfsr_checker.sv
module tb_axis_lfsr_checker;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;

  logic        clear = 1'b0;
  logic [63:0] tdata = '0;
  logic        tvalid = 1'b0;
  logic        tready;
  logic        locked;
  logic [31:0] word_count, error_count, bit_error_count;

  logic        s_clear = 1'b0;
  logic [63:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_locked;
  logic [3:0]  s_word_count, s_error_count, s_bit_error_count;

  always #5 aclk = ~aclk;

  axis_lfsr_checker #(
    .AXIS_TDATA_WIDTH(64), .CNTR_WIDTH(32), .LOCK_COUNT(4), .UNLOCK_COUNT(4)
  ) u_main (
    .aclk(aclk), .aresetn(aresetn), .clear(clear),
    .s_axis_tready(tready), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .locked(locked), .word_count(word_count), .error_count(error_count),
    .bit_error_count(bit_error_count)
  );

  axis_lfsr_checker #(
    .AXIS_TDATA_WIDTH(64), .CNTR_WIDTH(4), .LOCK_COUNT(4), .UNLOCK_COUNT(4)
  ) u_sat (
    .aclk(aclk), .aresetn(aresetn), .clear(s_clear),
    .s_axis_tready(s_tready), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .locked(s_locked), .word_count(s_word_count), .error_count(s_error_count),
    .bit_error_count(s_bit_error_count)
  );

  typedef struct {
    logic        lk;
    logic [31:0] w;
    logic [31:0] e;
    logic [31:0] b;
  } exp_t;

  exp_t        q[$];
  int          n_assert = 0;
  int          n_fail   = 0;

  // Per-DUT bench state: index 0 = main, 1 = 4-bit counters.
  logic [63:0] gen    [2];
  logic        cur_lk [2];
  logic [31:0] tw     [2];
  logic [31:0] te     [2];
  logic [31:0] tb     [2];
  logic [31:0] lim    [2];

  function automatic logic [63:0] gen_next(input logic [63:0] x);
    return {x[62:0], x[62] ~^ x[61]};
  endfunction

  function automatic logic [31:0] satadd(input logic [31:0] a, input int inc, input logic [31:0] l);
    longint t;
    t = longint'(a) + longint'(inc);
    return (t > longint'(l)) ? l : t[31:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic bench_reset_state(input int s);
    gen[s]    = 64'h5555555555555555;
    cur_lk[s] = 1'b0;
    tw[s] = '0; te[s] = '0; tb[s] = '0;
  endtask

  // Drive one cycle on DUT s: data = generator word XOR mask.
  task automatic step(input int s, input logic [63:0] mask, input logic v,
                      input logic clr, input logic lk_after);
    exp_t        x;
    logic [63:0] g;
    @(negedge aclk);
    g = gen[s];
    if (s == 0) begin
      tdata = g ^ mask; tvalid = v; clear = clr;
    end else begin
      s_tdata = g ^ mask; s_tvalid = v; s_clear = clr;
    end
    if (clr) begin
      tw[s] = '0; te[s] = '0; tb[s] = '0;
    end else if (v && cur_lk[s]) begin
      tw[s] = satadd(tw[s], 1, lim[s]);
      if (mask != '0) begin
        te[s] = satadd(te[s], 1, lim[s]);
        tb[s] = satadd(tb[s], $countones(mask), lim[s]);
      end
    end
    if (v) begin
      cur_lk[s] = lk_after;
      gen[s]    = gen_next(g);
    end
    x.lk = cur_lk[s]; x.w = tw[s]; x.e = te[s]; x.b = tb[s];
    q.push_back(x);
    @(posedge aclk);
    #1;
    tvalid = 1'b0; clear = 1'b0; s_tvalid = 1'b0; s_clear = 1'b0;
    x = q.pop_front();
    if (s == 0) begin
      chk("locked", {63'd0, locked}, {63'd0, x.lk});
      chk("word_count", {32'd0, word_count}, {32'd0, x.w});
      chk("error_count", {32'd0, error_count}, {32'd0, x.e});
      chk("bit_error_count", {32'd0, bit_error_count}, {32'd0, x.b});
    end else begin
      chk("sat_locked", {63'd0, s_locked}, {63'd0, x.lk});
      chk("sat_word_count", {60'd0, s_word_count}, {32'd0, x.w});
      chk("sat_error_count", {60'd0, s_error_count}, {32'd0, x.e});
      chk("sat_bit_error_count", {60'd0, s_bit_error_count}, {32'd0, x.b});
    end
  endtask

  initial begin
    int unsigned nvalid;
    logic [31:0] w_before;
    logic        v;

    lim[0] = 32'hFFFF_FFFF;
    lim[1] = 32'd15;
    bench_reset_state(0);
    bench_reset_state(1);

    // Reset state
    repeat (2) @(posedge aclk);
    #1;
    chk("rst_tready", {63'd0, tready}, 64'd0);
    chk("rst_locked", {63'd0, locked}, 64'd0);
    chk("rst_counters", {word_count, error_count | bit_error_count}, 64'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    chk("tready_after_rst", {63'd0, tready}, 64'd1);
    chk("sat_tready_after_rst", {63'd0, s_tready}, 64'd1);

    // Clean lock: 1 seed + 4 matches
    for (int i = 1; i <= 5; i++) step(0, '0, 1'b1, 1'b0, i == 5);
    for (int i = 0; i < 100; i++) step(0, '0, 1'b1, 1'b0, 1'b1);
    chk("clean_words_100", {32'd0, word_count}, 64'd100);

    // Single-bit error, then the free-running reference keeps matching
    step(0, 64'h1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(0, '0, 1'b1, 1'b0, 1'b1);
    chk("single_bit_errs", {error_count, bit_error_count}, {32'd1, 32'd1});

    // Multi-bit error
    step(0, 64'hFF, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(0, '0, 1'b1, 1'b0, 1'b1);
    chk("multi_bit_errs", {error_count, bit_error_count}, {32'd2, 32'd9});

    // Loss of lock: four all-zero words replace generator words
    for (int i = 0; i < 4; i++) step(0, gen[0], 1'b1, 1'b0, i < 3);
    chk("unlocked_after_4", {63'd0, locked}, 64'd0);
    // Re-lock: first beat reseeds, then 4 matches
    for (int i = 1; i <= 5; i++) step(0, '0, 1'b1, 1'b0, i == 5);
    for (int i = 0; i < 5; i++) step(0, '0, 1'b1, 1'b0, 1'b1);

    // Gaps on tvalid
    w_before = word_count;
    nvalid   = 0;
    for (int i = 0; i < 40; i++) begin
      v = 1'($urandom_range(0, 1));
      if (v) nvalid++;
      step(0, '0, v, 1'b0, 1'b1);
    end
    chk("gap_word_delta", {32'd0, word_count - w_before}, {32'd0, nvalid});

    // Clear coinciding with an errored beat
    step(0, 64'h3, 1'b1, 1'b1, 1'b1);
    chk("clear_wins", {word_count, error_count | bit_error_count}, 64'd0);
    step(0, '0, 1'b1, 1'b0, 1'b1);

    // Saturation on 4-bit counters: errored beats interleaved so lock holds
    for (int i = 1; i <= 5; i++) step(1, '0, 1'b1, 1'b0, i == 5);
    for (int i = 0; i < 20; i++) begin
      step(1, 64'h3, 1'b1, 1'b0, 1'b1);
      step(1, '0, 1'b1, 1'b0, 1'b1);
    end
    chk("sat_err_15", {60'd0, s_error_count}, 64'd15);
    chk("sat_bit_15", {60'd0, s_bit_error_count}, 64'd15);

    // Reset mid-stream with a beat presented in the same cycle
    @(negedge aclk);
    aresetn = 1'b0;
    tdata   = gen[0];
    tvalid  = 1'b1;
    @(posedge aclk);
    #1;
    tvalid = 1'b0;
    chk("midrst_tready", {63'd0, tready}, 64'd0);
    chk("midrst_locked", {63'd0, locked}, 64'd0);
    chk("midrst_counters", {word_count, error_count | bit_error_count}, 64'd0);
    cur_lk[0] = 1'b0;
    tw[0] = '0; te[0] = '0; tb[0] = '0;
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    chk("midrst_tready_back", {63'd0, tready}, 64'd1);
    for (int i = 1; i <= 5; i++) step(0, '0, 1'b1, 1'b0, i == 5);
    for (int i = 0; i < 3; i++) step(0, '0, 1'b1, 1'b0, 1'b1);
    chk("relock_words", {32'd0, word_count}, 64'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
